// File: rtl/lift_row_seq_pkg.sv
// Shared constants, flag positions and FSM encoding for the 5/3 lifting row sequencer.
package lift_pkg;

    localparam int FLAG_PRED     = 0;
    localparam int FLAG_FWD      = 1;
    localparam int FLAG_LOSSLESS = 2;

    localparam int W_SAM_DEF = 9;
    localparam int W_RES_DEF = 10;

    // Clamp range for RAM words narrowed to the lift_step sample width.
    localparam int SAT_MAX = 255;
    localparam int SAT_MIN = -256;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAST,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/lift_row_seq_addr_gen.sv
// Maps target index k and window slot (0 = left, 1 = centre, 2 = right) to a RAM
// address, mirroring symmetrically at both row ends.
module lift_addr_gen #(
    parameter int ROW_LEN = 8,
    parameter int ADDR_W  = 3
) (
    input  logic [ADDR_W-1:0] k,
    input  logic [1:0]        slot,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(ROW_LEN - 1);
    localparam logic [ADDR_W-1:0] K_MIRR = ADDR_W'(ROW_LEN - 2);

    always_comb begin
        addr = k;
        case (slot)
            2'd0:    addr = (k == '0) ? ADDR_W'(1) : k - ADDR_W'(1);
            2'd2:    addr = (k == K_LAST) ? K_MIRR : k + ADDR_W'(1);
            default: addr = k;
        endcase
    end

endmodule

// File: rtl/lift_row_seq.sv
// Row sequencer for lift_step: fetches mirrored left/centre/right windows from the
// sample RAM, hands them to lift_step and writes results back, one pass per parity.
module lift_row_seq
    import lift_pkg::*;
#(
    parameter int ROW_LEN = 8,
    parameter int ADDR_W  = 3,
    parameter int W_SAM   = W_SAM_DEF,
    parameter int W_RES   = W_RES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              fwd_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              sat_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [W_RES-1:0]  rd_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [W_RES-1:0]  wr_data_o,
    output logic [2:0]        flags_o,
    output logic              update_o,
    output logic [W_SAM-1:0]  left_o,
    output logic [W_SAM-1:0]  sam_o,
    output logic [W_SAM-1:0]  right_o,
    input  logic [W_RES-1:0]  res_i,
    input  logic              update_i
);

    localparam logic [ADDR_W:0]         LEN    = (ADDR_W + 1)'(ROW_LEN);
    localparam logic signed [W_RES-1:0] RES_HI = W_RES'(SAT_MAX);
    localparam logic signed [W_RES-1:0] RES_LO = W_RES'(SAT_MIN);
    localparam logic [W_SAM-1:0]        SAM_HI = W_SAM'(SAT_MAX);
    localparam logic [W_SAM-1:0]        SAM_LO = W_SAM'(SAT_MIN);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] k_q;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        slot_q;
    logic              fwd_q, pred_q, second_q, sat_q;
    logic [W_SAM-1:0]  cap_l, cap_s;
    logic [W_RES-1:0]  res_q;
    logic              pass_end;
    logic              rd_hit;
    logic [W_SAM-1:0]  rd_sam;

    lift_addr_gen #(
        .ROW_LEN(ROW_LEN),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .k   (k_q),
        .slot(slot_q),
        .addr(addr)
    );

    assign pass_end = ({1'b0, k_q} + (ADDR_W + 1)'(2)) >= LEN;

    always_comb begin
        rd_hit = 1'b0;
        rd_sam = rd_data_i[W_SAM-1:0];
        if ($signed(rd_data_i) > RES_HI) begin
            rd_hit = 1'b1;
            rd_sam = SAM_HI;
        end else if ($signed(rd_data_i) < RES_LO) begin
            rd_hit = 1'b1;
            rd_sam = SAM_LO;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = FETCH;
            FETCH:   if (slot_q == 2'd2) state_d = LAST;
            LAST:    state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (update_i) state_d = WRITE;
            WRITE:   state_d = (pass_end && second_q) ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            k_q      <= '0;
            slot_q   <= '0;
            fwd_q    <= 1'b0;
            pred_q   <= 1'b0;
            second_q <= 1'b0;
            sat_q    <= 1'b0;
            cap_l    <= '0;
            cap_s    <= '0;
            left_o   <= '0;
            sam_o    <= '0;
            right_o  <= '0;
            res_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start_i) begin
                    fwd_q    <= fwd_i;
                    pred_q   <= fwd_i;
                    second_q <= 1'b0;
                    sat_q    <= 1'b0;
                    slot_q   <= '0;
                    k_q      <= fwd_i ? ADDR_W'(1) : '0;
                end
                // RAM data lags the address by one cycle: slot 1 sees the left word, slot 2 the centre.
                FETCH: begin
                    slot_q <= (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
                    if (slot_q == 2'd1) cap_l <= rd_sam;
                    if (slot_q == 2'd2) cap_s <= rd_sam;
                    if (slot_q != 2'd0 && rd_hit) sat_q <= 1'b1;
                end
                LAST: begin
                    left_o  <= cap_l;
                    sam_o   <= cap_s;
                    right_o <= rd_sam;
                    if (rd_hit) sat_q <= 1'b1;
                end
                WAIT: if (update_i) res_q <= res_i;
                WRITE: begin
                    if (!pass_end) begin
                        k_q <= k_q + ADDR_W'(2);
                    end else if (!second_q) begin
                        second_q <= 1'b1;
                        pred_q   <= !pred_q;
                        k_q      <= pred_q ? '0 : ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy_o    = (state_q != IDLE);
        done_o    = (state_q == DONE);
        rd_en_o   = (state_q == FETCH);
        rd_addr_o = (state_q == FETCH) ? addr : '0;
        wr_en_o   = (state_q == WRITE);
        wr_addr_o = (state_q == WRITE) ? k_q : '0;
        update_o  = (state_q == ISSUE);
        flags_o   = '0;
        if (state_q != IDLE) begin
            flags_o[FLAG_PRED]     = pred_q;
            flags_o[FLAG_FWD]      = fwd_q;
            flags_o[FLAG_LOSSLESS] = 1'b1;
        end
    end

    assign wr_data_o = res_q;
    assign sat_o     = sat_q;

endmodule

// File: tb/tb_lift_row_seq.sv
// Bench for lift_row_seq: sample RAM and lift_step responder models, plus a
// whole-row reference that predicts reads, operands, writes and final RAM contents.
module tb_lift_row_seq;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int WS = 9;
    localparam int WR = 10;

    logic          clk = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic          fwd_i = 1'b0;
    logic          busy_o, done_o, sat_o, rd_en_o, wr_en_o, update_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic [WR-1:0] rd_data_i = '0;
    logic [WR-1:0] wr_data_o;
    logic [WR-1:0] res_i;
    logic [2:0]    flags_o;
    logic [WS-1:0] left_o, sam_o, right_o;
    logic          update_i;
    logic          model_upd;
    logic          stray = 1'b0;
    logic [51:0]   all_out;

    assign update_i = model_upd | stray;
    assign all_out  = {busy_o, done_o, sat_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o,
                       flags_o, update_o, left_o, sam_o, right_o};

    always #5 clk = ~clk;

    lift_row_seq #(
        .ROW_LEN(N),
        .ADDR_W (AW),
        .W_SAM  (WS),
        .W_RES  (WR)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n_i),
        .start_i  (start_i),
        .fwd_i    (fwd_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .sat_o    (sat_o),
        .rd_en_o  (rd_en_o),
        .rd_addr_o(rd_addr_o),
        .rd_data_i(rd_data_i),
        .wr_en_o  (wr_en_o),
        .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o),
        .flags_o  (flags_o),
        .update_o (update_o),
        .left_o   (left_o),
        .sam_o    (sam_o),
        .right_o  (right_o),
        .res_i    (res_i),
        .update_i (update_i)
    );

    // Sample RAM: registered read, write-through from the DUT, bulk load from the bench.
    logic signed [WR-1:0] ram      [N];
    logic signed [WR-1:0] load_val [N];
    logic                 load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) ram[i] <= load_val[i];
        end else if (wr_en_o) begin
            ram[wr_addr_o] <= wr_data_o;
        end
        if (rd_en_o) rd_data_i <= ram[rd_addr_o];
    end

    function automatic int lift_fn(input int l, input int s, input int r, input bit pred);
        if (pred) return s - ((l + r) >>> 1);
        return s + ((l + r + 2) >>> 2);
    endfunction

    // lift_step responder: answers each update strobe after 'lat' cycles.
    int lat = 1;
    int mres;
    initial begin
        model_upd = 1'b0;
        res_i     = '0;
        forever begin
            @(negedge clk);
            if (update_o === 1'b1) begin
                mres = lift_fn(int'($signed(left_o)), int'($signed(sam_o)),
                               int'($signed(right_o)), flags_o[0]);
                repeat (lat) @(posedge clk);
                #1;
                res_i     = WR'(mres);
                model_upd = 1'b1;
                @(posedge clk);
                #1;
                model_upd = 1'b0;
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: expected behaviour of a whole row from the current RAM contents.
    int exp_rd[$], exp_wa[$], exp_wd[$], exp_l[$], exp_s[$], exp_r[$], exp_f[$];
    int exp_ram[N];
    bit exp_sat;
    int got_rd[$], got_wa[$], got_wd[$], got_l[$], got_s[$], got_r[$], got_f[$];

    function automatic int sat_val(input int v);
        if (v > 255) begin exp_sat = 1'b1; return 255; end
        if (v < -256) begin exp_sat = 1'b1; return -256; end
        return v;
    endfunction

    task automatic build_expect(input bit fwd);
        int m[N];
        int li, ri, l, s, r, res;
        bit pred;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        exp_l.delete(); exp_s.delete(); exp_r.delete(); exp_f.delete();
        exp_sat = 1'b0;
        for (int i = 0; i < N; i++) m[i] = int'(ram[i]);
        for (int p = 0; p < 2; p++) begin
            pred = (p == 0) ? fwd : !fwd;
            for (int k = (pred ? 1 : 0); k < N; k += 2) begin
                li = (k == 0) ? 1 : k - 1;
                ri = (k == N - 1) ? N - 2 : k + 1;
                exp_rd.push_back(li);
                exp_rd.push_back(k);
                exp_rd.push_back(ri);
                l = sat_val(m[li]);
                s = sat_val(m[k]);
                r = sat_val(m[ri]);
                res  = lift_fn(l, s, r, pred);
                m[k] = res;
                exp_wa.push_back(k);
                exp_wd.push_back(res);
                exp_l.push_back(l);
                exp_s.push_back(s);
                exp_r.push_back(r);
                exp_f.push_back(4 + (fwd ? 2 : 0) + (pred ? 1 : 0));
            end
        end
        for (int i = 0; i < N; i++) exp_ram[i] = m[i];
    endtask

    task automatic load_ram();
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    // One row: hold keeps start_i high throughout, stray_on pulses update_i in the first
    // FETCH cycle, rst_iss > 0 pulls reset in the WAIT that follows that ISSUE.
    task automatic run_row(input bit fwd, input int l, input bit hold, input bit stray_on,
                           input int rst_iss);
        int  n_iss, n_done, done_cyc, last_wr, proto, rst_cyc, end_cyc, cyc, nw, ni, nr;
        bit  busy1, sat1, prev_ui, prev_uo, full;
        lat = l;
        build_expect(fwd);
        got_rd.delete(); got_wa.delete(); got_wd.delete();
        got_l.delete(); got_s.delete(); got_r.delete(); got_f.delete();
        n_iss = 0; n_done = 0; done_cyc = -1; last_wr = -1; proto = 0;
        rst_cyc = -1; end_cyc = -1; busy1 = 1'b0; sat1 = 1'b1;
        prev_ui = 1'b0; prev_uo = 1'b0;
        full = (rst_iss == 0);
        @(negedge clk);
        fwd_i   = fwd;
        start_i = 1'b1;
        for (cyc = 0; cyc < 600; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (rd_en_o) got_rd.push_back(int'(rd_addr_o));
            if (wr_en_o) begin
                got_wa.push_back(int'(wr_addr_o));
                got_wd.push_back(int'($signed(wr_data_o)));
                last_wr = cyc;
                if (!prev_ui) proto++;
            end
            if (update_o) begin
                n_iss++;
                got_l.push_back(int'($signed(left_o)));
                got_s.push_back(int'($signed(sam_o)));
                got_r.push_back(int'($signed(right_o)));
                got_f.push_back(int'(flags_o));
                if (prev_uo) proto++;
            end
            if (done_o) begin
                n_done++;
                done_cyc = cyc;
                if (!busy_o) proto++;
            end
            if (cyc == 1) begin
                busy1 = busy_o;
                sat1  = sat_o;
            end
            prev_ui = update_i;
            prev_uo = update_o;
            if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
                check("rst_mid_outputs_zero", int'(all_out !== '0), 0);
                rst_n_i = 1'b1;
            end
            if (cyc == 1 && !hold) begin
                start_i = 1'b0;
                fwd_i   = !fwd;
            end
            if (stray_on) stray = (cyc == 1);
            if (!full && rst_cyc < 0 && n_iss == rst_iss && !update_o) begin
                rst_n_i = 1'b0;
                rst_cyc = cyc;
                end_cyc = cyc + 16;
            end
            if (done_o && hold) start_i = 1'b0;
            if (done_cyc >= 0 && end_cyc < 0) end_cyc = cyc + 20;
            if (cyc == end_cyc) break;
        end
        start_i = 1'b0;
        stray   = 1'b0;
        check("row_completed_in_budget", int'(end_cyc >= 0 && cyc == end_cyc), 1);
        ni = full ? N : rst_iss;
        nw = full ? N : rst_iss - 1;
        nr = 3 * ni;
        check("n_reads", got_rd.size(), nr);
        for (int i = 0; i < nr && i < got_rd.size(); i++)
            check($sformatf("rd_addr[%0d]", i), got_rd[i], exp_rd[i]);
        check("n_writes", got_wa.size(), nw);
        for (int i = 0; i < nw && i < got_wa.size(); i++) begin
            check($sformatf("wr_addr[%0d]", i), got_wa[i], exp_wa[i]);
            check($sformatf("wr_data[%0d]", i), got_wd[i], exp_wd[i]);
        end
        check("n_issue", got_l.size(), ni);
        for (int i = 0; i < ni && i < got_l.size(); i++) begin
            check($sformatf("left[%0d]", i), got_l[i], exp_l[i]);
            check($sformatf("sam[%0d]", i), got_s[i], exp_s[i]);
            check($sformatf("right[%0d]", i), got_r[i], exp_r[i]);
            check($sformatf("flags[%0d]", i), got_f[i], exp_f[i]);
        end
        check("n_done", n_done, full ? 1 : 0);
        check("protocol_errors", proto, 0);
        check("busy_cycle1", int'(busy1), 1);
        check("sat_cleared_at_start", int'(sat1), 0);
        check("busy_after_row", int'(busy_o), 0);
        if (full) begin
            check("last_write_cycle", last_wr, N * (6 + l));
            check("done_cycle", done_cyc, N * (6 + l) + 1);
            check("sat_sticky", int'(sat_o), int'(exp_sat));
            for (int i = 0; i < N; i++)
                check($sformatf("ram[%0d]", i), int'(ram[i]), exp_ram[i]);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < N; i++) load_val[i] = WR'(10 * (i + 1));
        load_ram();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", int'(all_out !== '0), 0);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk);

        // Start and reset together: reset wins.
        rst_n_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("start_under_reset_busy", int'(busy_o), 0);
        rst_n_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);

        load_ramp();
        run_row(1'b1, 1, 1'b0, 1'b0, 0);
        check("fwd_first_flags", got_f[0], 7);
        check("fwd_second_flags", got_f[4], 6);

        load_ramp();
        run_row(1'b0, 1, 1'b0, 1'b0, 0);
        check("inv_first_flags", got_f[0], 4);
        check("inv_second_flags", got_f[4], 5);

        load_ramp();
        load_val[2] = WR'(300);
        load_val[4] = WR'(-300);
        load_ram();
        run_row(1'b1, 1, 1'b0, 1'b0, 0);
        check("sat_left_clamp", got_l[1], 255);
        check("sat_right_clamp", got_r[1], -256);
        check("sat_flag", int'(sat_o), 1);

        load_ramp();
        run_row(1'b1, 5, 1'b0, 1'b0, 0);

        load_ramp();
        run_row(1'b1, 4, 1'b0, 1'b0, 3);
        run_row(1'b1, 1, 1'b0, 1'b0, 0);

        load_ramp();
        run_row(1'b0, 2, 1'b1, 1'b1, 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) load_val[i] = WR'(int'($urandom_range(0, 640)) - 320);
            load_ram();
            run_row(1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), 1'b0, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lift_row_seq.md
Name: lift_row_seq

Overview:
- Row sequencer sitting directly upstream of lift_step in the 5/3 lossless JPEG-2000 DWT path.
- Walks one row held in a simple-dual-port sample RAM and builds each left/sam/right triple with symmetric boundary mirroring.
- Drives flags/update into lift_step, waits for its returned update strobe, and writes the 10-bit result back in place.
- Runs two passes per row (predict on odd indices, update on even indices), ordered for forward or inverse transform.

Parameters:
- ROW_LEN, 8, samples per row; even, >= 4.
- ADDR_W, 3, RAM address width; ceil(log2(ROW_LEN)).
- W_SAM, 9, signed sample width into lift_step.
- W_RES, 10, signed RAM word / lift_step result width.

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- rst_n_i  in  1  synchronous active-low reset.
- start_i  in  1  start one row; sampled only in IDLE.
- fwd_i  in  1  1 = forward, 0 = inverse; latched at start.
- busy_o  out  1  high from the cycle after start through the done_o cycle.
- done_o  out  1  one-cycle pulse after the last write.
- sat_o  out  1  sticky; set on any saturation; cleared at start.
- rd_en_o  out  1  RAM read enable.
- rd_addr_o  out  ADDR_W  RAM read address.
- rd_data_i  in  W_RES  RAM read data, valid 1 cycle after rd_en_o.
- wr_en_o  out  1  RAM write enable.
- wr_addr_o  out  ADDR_W  RAM write address.
- wr_data_o  out  W_RES  RAM write data (= res_i).
- flags_o  out  3  to lift_step flags_i.
- update_o  out  1  to lift_step update_i; one-cycle pulse.
- left_o  out  W_SAM  to lift_step left_i.
- sam_o  out  W_SAM  to lift_step sam_i.
- right_o  out  W_SAM  to lift_step right_i.
- res_i  in  W_RES  from lift_step res_o.
- update_i  in  1  from lift_step update_o; marks res_i valid.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; window registers cleared.
- Reset mid-row: same as reset; no further RAM writes; done_o is not pulsed.
- Flags:
  - flags_o[0] = 1 in predict pass, 0 in update pass.
  - flags_o[1] = latched fwd_i.
  - flags_o[2] = 1 constant (5/3 lossless).
  - flags_o holds its value for the whole pass.
- Pass order: forward runs predict (k = 1,3,..,N-1) then update (k = 0,2,..,N-2). Inverse runs update first, then predict.
- Mirroring:
  - left index = k-1, except k = 0 uses 1.
  - right index = k+1, except k = N-1 uses N-2.
- FSM states: IDLE, FETCH, LAST, ISSUE, WAIT, WRITE, DONE. Per target index k:
  - FETCH (3 cycles): rd_en_o = 1 with addresses left, k, right in order.
  - LAST (1 cycle): captures the final read.
  - ISSUE: update_o = 1; left/sam/right outputs hold the window until the next ISSUE.
  - WAIT: hold until update_i = 1; there is no timeout.
  - WRITE: wr_en_o = 1, wr_addr_o = k, wr_data_o = res_i captured on update_i.
  - After WRITE, advance to k+2 → FETCH; on pass end, switch pass → FETCH; after the second pass → DONE.
  - DONE: done_o = 1 → IDLE.
- Timing: 7 cycles per sample when lift_step returns update_i 1 cycle after update_o; WAIT stretches otherwise.
- Saturation: RAM word to W_SAM signed clamps to [-256, 255]; sets sat_o.
- update_i outside WAIT: ignored.
- start_i while busy: ignored.
- start_i and reset asserted together: reset wins.
- Write/read hazard: none. Writes never target an address read later in the same pass; the second pass rereads the written values.

Decomposition:
- Package lift_pkg holds:
  - flag bit positions FLAG_PRED = 0, FLAG_FWD = 1, FLAG_LOSSLESS = 2;
  - W_SAM / W_RES defaults;
  - FSM state enum;
  - saturation limits.
- Sub-module lift_addr_gen: combinational. Maps (k, slot 0..2) to a mirrored RAM address; parameterised by ROW_LEN.

Test Plan:
- Forward, N = 8, RAM = 10,20,..,80, bench lift_step model with 1-cycle latency, start at cycle 0 ->
  - read triples 0,1,2 | 2,3,4 | 4,5,6 | 6,7,6, then 1,0,1 | 1,2,3 | 3,4,5 | 5,6,7;
  - writes to 1,3,5,7,0,2,4,6;
  - last wr_en_o at cycle 56, done_o at 57;
  - flags_o = 3'b111 then 3'b110.
- Inverse, same row -> flags_o 3'b100 first (update pass, reads 1,0,1 first), then 3'b101; writes to 0,2,4,6,1,3,5,7.
- Saturation: RAM[2] = 300 and RAM[4] = -300 -> left_o/right_o show 255 and -256 at the relevant ISSUE; sat_o = 1 through done; cleared at next start.
- Stretched handshake: model delays update_i by 5 cycles -> update_o stays a single pulse; wr_en_o exactly one cycle after update_i; no extra reads meanwhile.
- Reset mid-row: rst_n_i = 0 during the 3rd sample's WAIT -> next cycle all outputs 0; no write for that sample; done_o never pulses; a fresh start then completes normally.
- start_i held high through a row plus a stray update_i in FETCH -> exactly one row processed; the stray strobe causes no write.
